// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM serial link (receiver and transmitter).
package tdm_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } tdm_state_e;

    function automatic int slot_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/tdm_demux_rx_sat_counter.sv
// Saturating up-counter with async active-low clear.
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_demux_rx.sv
// Receive side of the 1-bit TDM link: rebuilds N-bit frames from slots.
module tdm_demux_rx
    import tdm_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int CW = 8,
    localparam int SW = slot_w(N)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          in_valid,
    input  logic          in_bit,
    input  logic          frame_sync,
    output logic [N-1:0]  ch_out,
    output logic          frame_done,
    output logic          sync_err,
    output logic [CW-1:0] drop_cnt,
    output logic [SW-1:0] slot,
    output logic          locked
);

    tdm_state_e    state_q;
    logic [SW-1:0] slot_q;
    logic [N-1:0]  shadow_q;
    logic [N-1:0]  shadow_d;
    logic [N-1:0]  ch_out_q;
    logic          frame_done_q;
    logic          sync_err_q;
    logic          last_slot;
    logic          drop_en;

    assign last_slot = (slot_q == SW'(N - 1));
    assign drop_en   = in_valid && !frame_sync && (state_q == HUNT);

    always_comb begin
        shadow_d         = shadow_q;
        shadow_d[slot_q] = in_bit;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= HUNT;
            slot_q       <= '0;
            shadow_q     <= '0;
            ch_out_q     <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            if (in_valid) begin
                unique case (state_q)
                    HUNT: begin
                        if (frame_sync) begin
                            shadow_q[0] <= in_bit;
                            slot_q      <= SW'(1);
                            state_q     <= RECV;
                        end
                    end
                    RECV: begin
                        // A sync mid-frame, even on the last slot, restarts.
                        if (frame_sync) begin
                            sync_err_q  <= 1'b1;
                            shadow_q[0] <= in_bit;
                            slot_q      <= SW'(1);
                        end else begin
                            shadow_q <= shadow_d;
                            if (last_slot) begin
                                ch_out_q     <= shadow_d;
                                frame_done_q <= 1'b1;
                                slot_q       <= '0;
                                state_q      <= HUNT;
                            end else begin
                                slot_q <= slot_q + SW'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    sat_counter #(
        .CW(CW)
    ) u_drop_cnt (
        .clk_i (clock),
        .rst_ni(resetn),
        .en_i  (drop_en),
        .cnt_o (drop_cnt)
    );

    assign ch_out     = ch_out_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign slot       = slot_q;
    assign locked     = (state_q == RECV);

endmodule
